// File: rtl/alu_instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: instruction layout,
// instruction types and FSM states.
package alu_seq_pkg;

   localparam logic [1:0] TYPE_ALU = 2'b00;
   localparam logic [1:0] TYPE_LI  = 2'b01;

   // Field layout of a 32-bit micro-instruction; rs2 aliases imm[4:0] (bits 14:10).
   typedef struct packed {
      logic [1:0]  itype;
      logic [1:0]  alu_op;
      logic [1:0]  rsvd;
      logic [15:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rd;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WB,
      ST_ILL
   } state_t;

   function automatic logic is_legal(input instr_t ins);
      return (ins.itype == TYPE_ALU) || (ins.itype == TYPE_LI);
   endfunction

   function automatic logic [4:0] rs2_of(input instr_t ins);
      return ins.imm[4:0];
   endfunction

endpackage

// File: rtl/alu_instr_sequencer_fifo.sv
// Synchronous instruction FIFO with a separate occupancy count; no
// write-to-read bypass, so a word pushed into an empty FIFO is visible next cycle.
module instr_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control stage for the regfile + ALU datapath: buffers micro-instructions
// and steps each through read, result capture and write-back.
module alu_instr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic [4:0]  A1,
   output logic [4:0]  A2,
   output logic [1:0]  ALUOp,
   input  logic [31:0] ALUResult,
   output logic [4:0]  A3,
   output logic [31:0] WD3,
   output logic        WE3,
   output logic        res_valid,
   output logic [4:0]  res_rd,
   output logic [31:0] res_data,
   output logic        illegal,
   output logic        busy
);

   state_t      state;
   instr_t      ir;
   logic [31:0] res;
   logic [31:0] fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   logic        unused_rsvd;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

   instr_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_instr),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         ir    <= '0;
         res   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  ir    <= instr_t'(fifo_dout);
                  state <= is_legal(instr_t'(fifo_dout)) ? ST_EXEC : ST_ILL;
               end
            end
            ST_EXEC: begin
               res   <= (ir.itype == TYPE_ALU) ? ALUResult : {16'h0000, ir.imm};
               state <= ST_WB;
            end
            ST_WB:   state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes are pure decodes of registered state, so reset clears them immediately.
   assign A1        = ir.rs1;
   assign A2        = rs2_of(ir);
   assign ALUOp     = ir.alu_op;
   assign A3        = ir.rd;
   assign WD3       = res;
   assign WE3       = (state == ST_WB) && !(ZERO_REG && (ir.rd == 5'd0));
   assign res_valid = (state == ST_WB);
   assign res_rd    = ir.rd;
   assign res_data  = res;
   assign illegal   = (state == ST_ILL);
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   assign unused_rsvd = ^ir.rsvd;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench: sequencer wrapped with a register file and ALU, checked every cycle
// against an in-order architectural model of the instruction stream.
module tb_alu_instr_sequencer;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [4:0]  A1, A2, A3, res_rd;
   logic [1:0]  ALUOp;
   logic [31:0] ALUResult, WD3, res_data;
   logic        WE3, res_valid, illegal, busy;

   logic [31:0] rf     [32] = '{default: 32'h0};
   logic [31:0] mregs  [32] = '{default: 32'h0};
   logic [31:0] q[$];
   logic        acc_pend = 1'b0;
   logic [31:0] acc_ins = '0;
   int          checks = 0;
   int          errors = 0;
   int          retired = 0;
   int          illegals = 0;
   int          stall_seen = 0;

   alu_instr_sequencer #(.FIFO_DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .A1(A1), .A2(A2), .ALUOp(ALUOp), .ALUResult(ALUResult),
      .A3(A3), .WD3(WD3), .WE3(WE3), .res_valid(res_valid), .res_rd(res_rd),
      .res_data(res_data), .illegal(illegal), .busy(busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   function automatic logic [31:0] li(input logic [4:0] rd, input logic [15:0] imm);
      return {2'b01, 4'b0000, imm, 5'd0, rd};
   endfunction

   function automatic logic [31:0] alu_i(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [1:0] op);
      return {2'b00, op, 2'b00, 11'd0, rs2, rs1, rd};
   endfunction

   assign ALUResult = alu_ref(rf[A1], rf[A2], ALUOp);

   always @(posedge CLK) begin
      if (WE3) rf[A3] <= WD3;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Per-cycle scoreboard: retirement order, results and strobes against the model.
   always @(negedge CLK) begin
      logic [31:0] ins;
      logic [31:0] exp;
      if (!RST_N) begin
         q.delete();
         acc_pend = 1'b0;
         chk("rst_we3", WE3, 0);
         chk("rst_res_valid", res_valid, 0);
         chk("rst_illegal", illegal, 0);
         chk("rst_busy", busy, 0);
         chk("rst_in_ready", in_ready, 1);
      end else begin
         if (in_valid && !in_ready) stall_seen++;
         chk("busy", busy, (q.size() != 0));
         if (res_valid || illegal) begin
            if (q.size() == 0) begin
               chk("retire_without_instr", {res_valid, illegal}, 0);
            end else begin
               ins = q.pop_front();
               if (ins[31]) begin
                  chk("illegal_pulse", {res_valid, illegal}, 2'b01);
                  chk("illegal_we3", WE3, 0);
                  illegals++;
               end else begin
                  exp = (ins[31:30] == 2'b00) ?
                        alu_ref(mregs[ins[9:5]], mregs[ins[14:10]], ins[29:28]) :
                        {16'h0000, ins[25:10]};
                  chk("retire_pulse", {res_valid, illegal}, 2'b10);
                  chk("res_rd", res_rd, ins[4:0]);
                  chk("res_data", res_data, exp);
                  chk("we3", WE3, (ins[4:0] != 5'd0));
                  if (WE3) begin
                     chk("a3", A3, ins[4:0]);
                     chk("wd3", WD3, exp);
                  end
                  if (ins[4:0] != 5'd0) mregs[ins[4:0]] = exp;
                  retired++;
               end
            end
         end else begin
            chk("we3_quiet", WE3, 0);
         end
         acc_pend = in_valid && in_ready;
         acc_ins  = in_instr;
      end
   end

   always @(posedge CLK) begin
      if (RST_N && acc_pend) begin
         q.push_back(acc_ins);
         acc_pend = 1'b0;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] ins);
      logic r;
      logic done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_instr = ins;
      for (int w = 0; w < 300; w++) begin
         @(negedge CLK);
         r = in_ready;
         step();
         if (r) begin
            done = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge CLK);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 1, 0);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] old9, old8;
      int s0, r0;
      logic [31:0] ins;

      #2 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      wait_idle();

      // LI r1=5 and LI r2=7: write-back in the third cycle after accept
      send(li(5'd1, 16'd5));
      step(); step();
      chk("li1_we3", WE3, 1);
      chk("li1_a3", A3, 5'd1);
      chk("li1_wd3", WD3, 32'd5);
      chk("li1_res_valid", res_valid, 1);
      wait_idle();
      send(li(5'd2, 16'd7));
      step(); step();
      chk("li2_we3", WE3, 1);
      chk("li2_res_rd", res_rd, 5'd2);
      chk("li2_res_data", res_data, 32'd7);
      wait_idle();

      // ALU r3 = r1 + r2
      send(alu_i(5'd3, 5'd1, 5'd2, 2'b00));
      step();
      chk("alu_a1", A1, 5'd1);
      chk("alu_a2", A2, 5'd2);
      chk("alu_op", ALUOp, 2'b00);
      step();
      chk("alu_we3", WE3, 1);
      chk("alu_res_data", res_data, 32'd12);
      step();
      chk("alu_rf3", rf[3], 32'd12);
      wait_idle();

      // Write to r0 suppressed but still reported
      send(li(5'd0, 16'hBEEF));
      step(); step();
      chk("r0_res_valid", res_valid, 1);
      chk("r0_res_data", res_data, 32'h0000BEEF);
      chk("r0_we3", WE3, 0);
      wait_idle();
      chk("r0_rf0", rf[0], 32'h0);

      // Illegal instruction followed by a legal one
      send(32'hC000_0421);
      send(li(5'd4, 16'h1234));
      chk("ill_pulse", illegal, 1);
      chk("ill_we3", WE3, 0);
      step();
      chk("ill_one_cycle", illegal, 0);
      wait_idle();
      chk("ill_next_rf4", rf[4], 32'h1234);

      // Burst larger than the FIFO
      s0 = stall_seen;
      r0 = retired;
      for (int k = 0; k < 8; k++) send(li(5'(10 + k), 16'(16'h0100 + k)));
      wait_idle();
      chk("burst_stalled", (stall_seen > s0), 1);
      chk("burst_retired", retired - r0, 8);
      for (int k = 0; k < 8; k++) chk("burst_rf", rf[10 + k], 32'h0100 + k);

      // Randomized stream
      for (int n = 0; n < 200; n++) begin
         ins = $urandom;
         case ($urandom_range(0, 9))
            0:       ins[31:30] = 2'(2 + $urandom_range(0, 1));
            1, 2, 3, 4, 5: ins[31:30] = 2'b00;
            default: ins[31:30] = 2'b01;
         endcase
         send(ins);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) step();
      end
      wait_idle();

      // Reset during a write-back cycle
      old9 = rf[9];
      old8 = rf[8];
      send(li(5'd9, 16'hAAAA));
      send(li(5'd9, 16'h5555));
      send(li(5'd8, 16'h7777));
      chk("pre_reset_we3", WE3, 1);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_we3", WE3, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_illegal", illegal, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      step();
      chk("mid_rst_rf9", rf[9], old9);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (4) step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rf8", rf[8], old8);
      chk("post_rst_rf9", rf[9], old9);
      send(li(5'd9, 16'h1357));
      wait_idle();
      chk("post_rst_li", rf[9], 32'h1357);

      chk("queue_drained", q.size(), 0);
      for (int i = 0; i < 32; i++) chk("rf_vs_model", rf[i], mregs[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
